// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and the default
// frame geometry used by both the transmitter and the receiver.
package uart_pkg;

    localparam int OS_DEF       = 16;
    localparam int DBIT_MAX_DEF = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Out-of-range word lengths snap to the nearest length the datapath supports.
    function automatic logic [3:0] clamp_dbits(input logic [3:0] dbits, input int dbit_max);
        if (dbits < 4'd5) begin
            return 4'd5;
        end
        if (int'(dbits) > dbit_max) begin
            return 4'(dbit_max);
        end
        return dbits;
    endfunction

endpackage

// File: rtl/uart_rx_sample.sv
// Front end of the receiver: 2-flop synchroniser on the serial line and a
// 3-tap majority voter over the last three s_tick samples.
module uart_rx_sample (
    input  logic clk,
    input  logic reset,
    input  logic s_tick,
    input  logic rx,
    output logic rx_s,
    output logic vote
);

    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q, rx_s_d;
    logic [1:0] hist_q, hist_d;

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        hist_d    = hist_q;
        if (s_tick) begin
            hist_d = {hist_q[0], rx_s_q};
        end
    end

    // Synchroniser and history reset to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            hist_q    <= 2'b11;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            hist_q    <= hist_d;
        end
    end

    // On the tick that closes a window, hist_q holds the two earlier samples
    // and rx_s_q is the sample taken on that tick.
    assign rx_s = rx_s_q;
    assign vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver: 5..DBIT_MAX data bits, none/even/odd
// parity, 1 or 2 stop bits, majority-voted sampling with false-start rejection.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT_MAX = DBIT_MAX_DEF,
    parameter int OS       = OS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic                rx,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic [DBIT_MAX-1:0] rx_dout,
    output logic                rx_done_tick,
    output logic                parity_err,
    output logic                frame_err,
    output logic                break_det,
    output logic                rx_busy
);

    localparam int            SW        = $clog2(OS);
    localparam logic [SW-1:0] START_LIM = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] BIT_LIM   = SW'(OS - 1);

    logic rx_s;
    logic vote;

    uart_rx_sample u_sample (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick),
        .rx     (rx),
        .rx_s   (rx_s),
        .vote   (vote)
    );

    rx_state_e           state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [3:0]          n_q, n_d;
    logic [DBIT_MAX-1:0] data_q, data_d;
    logic [3:0]          dbits_q, dbits_d;
    logic [1:0]          parity_q, parity_d;
    logic                stop2_q, stop2_d;
    logic                par_flag_q, par_flag_d;
    logic                frame_flag_q, frame_flag_d;
    logic                any_one_q, any_one_d;
    logic [DBIT_MAX-1:0] dout_q, dout_d;
    logic                done_q, done_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                brk_q, brk_d;
    logic                busy_q, busy_d;

    logic win_end;
    logic par_en;
    logic par_exp;
    logic frame_next;
    logic any_next;

    assign win_end    = s_tick && (s_q == ((state_q == START) ? START_LIM : BIT_LIM));
    assign par_en     = (parity_q == PAR_EVEN) || (parity_q == PAR_ODD);
    assign par_exp    = (^data_q) ^ (parity_q == PAR_ODD);
    assign frame_next = frame_flag_q | ~vote;
    // any_one tracks whether any data, parity or stop vote was high, for break detection.
    assign any_next   = any_one_q | vote;

    always_comb begin
        // NOTE: every _d defaults to its current value so no branch of the case infers a latch.
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        data_d       = data_q;
        dbits_d      = dbits_q;
        parity_d     = parity_q;
        stop2_d      = stop2_q;
        par_flag_d   = par_flag_q;
        frame_flag_d = frame_flag_q;
        any_one_d    = any_one_q;
        dout_d       = dout_q;
        done_d       = 1'b0;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        brk_d        = brk_q;

        if (state_q != IDLE && s_tick) begin
            s_d = win_end ? '0 : s_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d  = START;
                    s_d      = '0;
                    dbits_d  = clamp_dbits(cfg_dbits, DBIT_MAX);
                    parity_d = cfg_parity;
                    stop2_d  = cfg_stop2;
                end
            end
            START: begin
                if (win_end) begin
                    if (vote) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = DATA;
                        n_d          = '0;
                        data_d       = '0;
                        par_flag_d   = 1'b0;
                        frame_flag_d = 1'b0;
                        any_one_d    = 1'b0;
                    end
                end
            end
            DATA: begin
                if (win_end) begin
                    data_d[n_q] = vote;
                    any_one_d   = any_next;
                    if (n_q == dbits_q - 4'd1) begin
                        n_d     = '0;
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        n_d = n_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (win_end) begin
                    par_flag_d = (vote != par_exp);
                    any_one_d  = any_next;
                    n_d        = '0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (win_end) begin
                    if (stop2_q && n_q == 4'd0) begin
                        n_d          = 4'd1;
                        frame_flag_d = frame_next;
                        any_one_d    = any_next;
                    end else begin
                        // Frame ends at mid-bit of the last stop bit.
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = data_q;
                        perr_d  = par_flag_q;
                        ferr_d  = frame_next;
                        brk_d   = ~any_next;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            data_q       <= '0;
            dbits_q      <= '0;
            parity_q     <= PAR_NONE;
            stop2_q      <= 1'b0;
            par_flag_q   <= 1'b0;
            frame_flag_q <= 1'b0;
            any_one_q    <= 1'b0;
            dout_q       <= '0;
            done_q       <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            brk_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            data_q       <= data_d;
            dbits_q      <= dbits_d;
            parity_q     <= parity_d;
            stop2_q      <= stop2_d;
            par_flag_q   <= par_flag_d;
            frame_flag_q <= frame_flag_d;
            any_one_q    <= any_one_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            brk_q        <= brk_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_dout      = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign break_det    = brk_q;
    assign rx_busy      = busy_q;

endmodule
